// File: rtl/sar_adc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sar_adc_pkg
// Description : Shared types and helpers for the SAR ADC controller.
// Revision    : 1.0 - initial release
// ============================================================================
package sar_adc_pkg;

    localparam real c_VSUP = 1.0;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_CONV = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        SAR_IDLE = c_ST_IDLE,
        SAR_CONV = c_ST_CONV,
        SAR_DONE = c_ST_DONE
    } sar_state_t;

    // Ideal code width in volts for an n-bit converter spanning 0..vsup.
    function automatic real sar_lsb(input real vsup, input int n);
        return vsup / real'(1 << n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sar_adc_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : sar_adc_ctrl_if
// Description : Control, analog and DAC signals between SAR controller,
//               requester and external DAC.
// Revision    : 1.0 - initial release
// ============================================================================
interface sar_adc_ctrl_if #(
    parameter int N = 3
);
    logic         start;
    real          vin;
    real          vdac;
    logic [N-1:0] dac_code;
    logic [N-1:0] result;
    logic         busy;
    logic         done;

    modport master (
        output start, vin,
        input  dac_code, result, busy, done
    );

    modport slave (
        input  start, vin, vdac,
        output dac_code, result, busy, done
    );

    modport dac (
        input  dac_code,
        output vdac
    );
endinterface
`default_nettype wire

// File: rtl/r_string_dac.sv
`default_nettype none
// ============================================================================
// Module      : r_string_dac
// Description : Behavioural resistor-string DAC, o_vout = code * VSUP / 2**N.
// Revision    : 1.0 - initial release
// ============================================================================
module r_string_dac #(
    parameter int  N    = 3,
    parameter real VSUP = 1.0
) (
    input  logic [N-1:0] i_code,
    output real          o_vout
);
    assign o_vout = real'(i_code) * VSUP / real'(1 << N);
endmodule
`default_nettype wire

// File: rtl/sar_comparator.sv
`default_nettype none
// ============================================================================
// Module      : sar_comparator
// Description : Ideal analog comparator, o_ge = (i_a >= i_b).
// Revision    : 1.0 - initial release
// ============================================================================
module sar_comparator (
    input  real  i_a,
    input  real  i_b,
    output logic o_ge
);
    assign o_ge = (i_a >= i_b);
endmodule
`default_nettype wire

// File: rtl/sar_adc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sar_adc_ctrl
// Description : Successive-approximation ADC controller driving an external DAC.
// Revision    : 1.0 - initial release
// ============================================================================
module sar_adc_ctrl
    import sar_adc_pkg::*;
#(
    parameter int N = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    sar_adc_ctrl_if.slave bus
);
    localparam int           c_IW       = $clog2(N);
    localparam logic [c_IW-1:0] c_IDX_MSB = c_IW'(N - 1);
    localparam logic [c_IW-1:0] c_IDX_ONE = c_IW'(1);
    localparam logic [N-1:0] c_CODE_MSB = {1'b1, {(N-1){1'b0}}};

    sar_state_t      r_state;
    logic [N-1:0]    r_code;
    logic [N-1:0]    r_result;
    logic [c_IW-1:0] r_idx;
    real             r_vin_held;
    logic            w_keep;

    sar_comparator u_cmp (
        .i_a  (r_vin_held),
        .i_b  (bus.vdac),
        .o_ge (w_keep)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= SAR_IDLE;
            r_code     <= '0;
            r_result   <= '0;
            r_idx      <= c_IDX_MSB;
            r_vin_held <= 0.0;
        end else begin
            case (r_state)
                // DONE hands back to IDLE on the same edge IDLE would sample
                // start, so a held start repeats every N+1 cycles.
                SAR_IDLE, SAR_DONE: begin
                    if (bus.start) begin
                        r_vin_held <= bus.vin;
                        r_code     <= c_CODE_MSB;
                        r_idx      <= c_IDX_MSB;
                        r_state    <= SAR_CONV;
                    end else begin
                        r_state    <= SAR_IDLE;
                    end
                end
                SAR_CONV: begin
                    r_code[r_idx] <= w_keep;
                    if (r_idx != '0) begin
                        r_code[r_idx - c_IDX_ONE] <= 1'b1;
                        r_idx                     <= r_idx - c_IDX_ONE;
                    end else begin
                        r_result <= {r_code[N-1:1], w_keep};
                        r_state  <= SAR_DONE;
                    end
                end
                default: r_state <= SAR_IDLE;
            endcase
        end
    end

    assign bus.dac_code = r_code;
    assign bus.result   = r_result;
    assign bus.busy     = (r_state == SAR_CONV);
    assign bus.done     = (r_state == SAR_DONE);

endmodule
`default_nettype wire

// File: doc/sar_adc_ctrl.md
SAR_ADC_CTRL -- requirements
Module: sar_adc_ctrl

Interface
REQ-001 The block SHALL have parameter N, default 3, meaning converter resolution in bits (legal range 2..8).
REQ-002 The block SHALL have port clk, input, 1, conversion clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, reset; it is asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1, a request to begin a conversion, sampled on the clock edge.
REQ-005 The block SHALL have port vin, input, real, the analog input to convert.
REQ-006 The block SHALL have port vdac, input, real, the feedback voltage from the external r_string_dac driven by dac_code.
REQ-007 The block SHALL have port dac_code, output, N, the trial code driving the external DAC.
REQ-008 The block SHALL have port result, output, N, the last completed conversion code.
REQ-009 The block SHALL have port busy, output, 1, high while a conversion is in progress.
REQ-010 The block SHALL have port done, output, 1, a one-cycle pulse when result updates.

Function
REQ-011 The block SHALL implement states IDLE, CONV and DONE.
REQ-012 IDLE: when start=1 at an edge, the block SHALL latch vin into vin_held, set dac_code to 1 followed by N-1 zeros, set bit index to N-1, and enter CONV.
REQ-013 CONV: at each edge the block SHALL keep bit[idx] if vin_held >= vdac and clear it otherwise; if idx>0 it SHALL set bit[idx-1] and decrement idx.
REQ-014 When idx=0 is resolved, the block SHALL load result with the final code, assert done and enter DONE.
REQ-015 DONE SHALL last one cycle; the block SHALL then deassert done and return to IDLE.
REQ-016 Latency: done SHALL rise exactly N clock edges after the edge that accepted start.
REQ-017 busy SHALL be 1 in CONV and 0 in IDLE and DONE.
REQ-018 start SHALL be ignored outside IDLE.
REQ-019 start held high SHALL trigger back-to-back conversions, one every N+1 cycles.
REQ-020 The comparison SHALL use vin_held only; vin changes during CONV SHALL not affect the result.
REQ-021 Ties (vin_held == vdac) SHALL keep the bit.
REQ-022 vin <= 0.0 SHALL yield result 0; vin >= VSUP SHALL yield all ones. No clamp logic is required beyond the comparison itself.
REQ-023 dac_code SHALL hold its final value after DONE until the next start.
REQ-024 result SHALL hold its value until the next DONE.

Reset
REQ-025 While rst_n=0 the block SHALL immediately force state IDLE, dac_code=0, result=0, busy=0, done=0, idx=N-1 and vin_held=0.0.
REQ-026 Reset mid-conversion SHALL abort without a done pulse and without updating result.
REQ-027 The first start SHALL be honoured at the first clock edge with rst_n=1.

Structure
REQ-028 Package sar_adc_pkg SHALL hold the state enum type sar_state_t.
REQ-029 Package sar_adc_pkg SHALL hold a function computing the ideal LSB, VSUP/2**N, for use by benches.
REQ-030 The comparison SHALL be a sub-module sar_comparator (real a, real b -> 1-bit a>=b).
REQ-031 The DAC SHALL stay external; the bench SHALL instantiate r_string_dac and connect it between dac_code and vdac.

Verification
REQ-032 N=3, VSUP=1.0, vin=0.6, start pulse -> dac_code sequence 100,110,101; done after 3 edges; result=100 (4).
REQ-033 vin=1.2 -> result=111; vin=-0.3 -> result=000; busy high for exactly 3 cycles in each case.
REQ-034 vin=0.5 (tie at the first trial) -> MSB kept; result=100.
REQ-035 vin=0.6 at start, then vin switched to 0.1 during CONV -> result=100 still.
REQ-036 rst_n pulsed low at the second CONV edge -> outputs 0 immediately; no done; result retains 0; a following start converts normally.
REQ-037 A formal property SHALL hold for all vin in [0,VSUP]: after done, |vin_held - result*VSUP/2**N| <= VSUP/2**N; and start held high SHALL give done every 4 cycles.
